// File: rtl/peecc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : peecc_pkg
// Description : Shared definitions for the PEECC self-test run controller.
//               Provides the default widths, the run sequencing limits, the
//               LFSR feedback mask and the controller state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package peecc_pkg;

    localparam int c_DATA_W      = 18;
    localparam int c_CNT_W       = 16;
    localparam int c_MAX_OUTST   = 11;
    localparam int c_TIMEOUT_CYC = 64;

    // Galois right-shift feedback mask for x^18 + x^11 + 1: bit (e-1) is set
    // for every non-constant term x^e.
    localparam logic [c_DATA_W-1:0] c_LFSR_POLY = 18'h20400;

    typedef enum logic [2:0] {
        c_ST_IDLE  = 3'd0,
        c_ST_LOAD  = 3'd1,
        c_ST_RUN   = 3'd2,
        c_ST_DRAIN = 3'd3,
        c_ST_DONE  = 3'd4,
        c_ST_ERR   = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/peecc_lfsr.sv
`default_nettype none
// ============================================================================
// Module      : peecc_lfsr
// Description : Galois LFSR word generator for self-test runs.
//   CLK     in  clock
//   RST     in  synchronous active-high reset, state returns to 1
//   Load    in  load SeedIn (a zero seed is replaced by 1)
//   SeedIn  in  seed value
//   Advance in  step the LFSR by one position
//   Q       out current LFSR state
// Revision    : 1.0 - initial release
// ============================================================================
module peecc_lfsr
    import peecc_pkg::*;
#(
    parameter int                DATA_W = c_DATA_W,
    parameter logic [DATA_W-1:0] POLY   = DATA_W'(c_LFSR_POLY)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              Load,
    input  logic [DATA_W-1:0] SeedIn,
    input  logic              Advance,
    output logic [DATA_W-1:0] Q
);

    logic [DATA_W-1:0] r_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_q <= DATA_W'(1);
        end else if (Load) begin
            // The all-zero state is a lock-up state for an LFSR.
            r_q <= (SeedIn == '0) ? DATA_W'(1) : SeedIn;
        end else if (Advance) begin
            r_q <= {1'b0, r_q[DATA_W-1:1]} ^ (r_q[0] ? POLY : '0);
        end
    end

    assign Q = r_q;

endmodule
`default_nettype wire

// File: rtl/peecc_run_controller.sv
`default_nettype none
// ============================================================================
// Module      : peecc_run_controller
// Description : Sequences the PEECC encode/decode datapath for self-test runs.
//               Issues NumWords LFSR words over a valid/ready handshake, keeps
//               the number of words in flight bounded, tallies the returned
//               IsEqual results and flags a stalled datapath with a watchdog.
//   CLK, RST               clock, synchronous active-high reset
//   Start/NumWords/Seed    run request (accepted when not Busy)
//   DpData/DpValidIn/DpReady  word issue handshake towards the datapath
//   DpValidOut/DpIsEqual   result strobe and result from the datapath
//   Busy/Done/Timeout/ProtoErr  run status
//   PassCount/FailCount    saturating result tallies
// Revision    : 1.0 - initial release
// ============================================================================
module peecc_run_controller
    import peecc_pkg::*;
#(
    parameter int DATA_W      = c_DATA_W,
    parameter int CNT_W       = c_CNT_W,
    parameter int MAX_OUTST   = c_MAX_OUTST,
    parameter int TIMEOUT_CYC = c_TIMEOUT_CYC
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              Start,
    input  logic [CNT_W-1:0]  NumWords,
    input  logic [DATA_W-1:0] Seed,
    output logic [DATA_W-1:0] DpData,
    output logic              DpValidIn,
    input  logic              DpReady,
    input  logic              DpValidOut,
    input  logic              DpIsEqual,
    output logic              Busy,
    output logic              Done,
    output logic              Timeout,
    output logic              ProtoErr,
    output logic [CNT_W-1:0]  PassCount,
    output logic [CNT_W-1:0]  FailCount
);

    localparam int c_OUT_W = $clog2(MAX_OUTST + 1);
    localparam int c_WD_W  = $clog2(TIMEOUT_CYC + 1);

    state_t              r_state;
    logic [CNT_W-1:0]    r_num;
    logic [DATA_W-1:0]   r_seed;
    logic [CNT_W-1:0]    r_issued;
    logic [c_OUT_W-1:0]  r_inflight;
    logic [c_WD_W-1:0]   r_wd;
    logic                r_valid;
    logic                r_busy;
    logic                r_done;
    logic                r_timeout;
    logic                r_protoerr;
    logic [CNT_W-1:0]    r_pass;
    logic [CNT_W-1:0]    r_fail;

    logic                w_xfer;
    logic                w_active;
    logic                w_result;
    logic                w_stray;
    logic [CNT_W-1:0]    w_issued_nxt;
    logic [c_OUT_W-1:0]  w_inflight_nxt;
    logic [c_WD_W-1:0]   w_wd_inc;
    logic                w_wd_expire;
    logic                w_can_issue;
    logic [DATA_W-1:0]   w_lfsr_q;

    peecc_lfsr #(
        .DATA_W (DATA_W)
    ) u_lfsr (
        .CLK     (CLK),
        .RST     (RST),
        .Load    (r_state == c_ST_LOAD),
        .SeedIn  (r_seed),
        .Advance (w_xfer),
        .Q       (w_lfsr_q)
    );

    always_comb begin
        w_xfer         = r_valid & DpReady;
        w_active       = (r_state == c_ST_RUN) || (r_state == c_ST_DRAIN);
        // A result with nothing in flight cannot belong to this run.
        w_result       = w_active & DpValidOut & (r_inflight != '0);
        w_stray        = w_active & DpValidOut & (r_inflight == '0);
        w_issued_nxt   = r_issued + CNT_W'(w_xfer);
        w_inflight_nxt = r_inflight + c_OUT_W'(w_xfer) - c_OUT_W'(w_result);
        w_wd_inc       = r_wd + 1'b1;
        w_wd_expire    = w_active & ~DpValidOut & (r_inflight != '0) &
                         (w_wd_inc == c_WD_W'(TIMEOUT_CYC));
        // Evaluated on post-edge counts so a held word is never withdrawn:
        // while valid waits for ready, issued is frozen and in-flight can
        // only fall.
        w_can_issue    = (w_issued_nxt < r_num) &&
                         (w_inflight_nxt < c_OUT_W'(MAX_OUTST));
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= c_ST_IDLE;
            r_num      <= '0;
            r_seed     <= '0;
            r_issued   <= '0;
            r_inflight <= '0;
            r_wd       <= '0;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_timeout  <= 1'b0;
            r_protoerr <= 1'b0;
            r_pass     <= '0;
            r_fail     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE, c_ST_DONE, c_ST_ERR: begin
                    if (Start) begin
                        r_state    <= c_ST_LOAD;
                        r_busy     <= 1'b1;
                        r_num      <= NumWords;
                        r_seed     <= Seed;
                        r_issued   <= '0;
                        r_inflight <= '0;
                        r_wd       <= '0;
                        r_timeout  <= 1'b0;
                        r_protoerr <= 1'b0;
                        r_pass     <= '0;
                        r_fail     <= '0;
                    end else if (r_state == c_ST_DONE) begin
                        r_state <= c_ST_IDLE;
                    end
                end

                c_ST_LOAD: begin
                    // The LFSR takes the seed at this edge, so the first
                    // word presented in RUN is the seed itself.
                    r_state <= c_ST_RUN;
                    r_valid <= (r_num != '0);
                end

                c_ST_RUN, c_ST_DRAIN: begin
                    r_issued   <= w_issued_nxt;
                    r_inflight <= w_inflight_nxt;

                    if (DpValidOut || (r_inflight == '0)) begin
                        r_wd <= '0;
                    end else begin
                        r_wd <= w_wd_inc;
                    end

                    if (w_stray) begin
                        r_protoerr <= 1'b1;
                    end

                    if (w_result) begin
                        if (DpIsEqual) begin
                            if (r_pass != '1) r_pass <= r_pass + 1'b1;
                        end else begin
                            if (r_fail != '1) r_fail <= r_fail + 1'b1;
                        end
                    end

                    if (w_wd_expire) begin
                        r_state   <= c_ST_ERR;
                        r_busy    <= 1'b0;
                        r_timeout <= 1'b1;
                        r_valid   <= 1'b0;
                    end else if ((r_state == c_ST_RUN) && (r_issued == r_num)) begin
                        r_state <= c_ST_DRAIN;
                        r_valid <= 1'b0;
                    end else if ((r_state == c_ST_DRAIN) && (r_inflight == '0)) begin
                        r_state <= c_ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_valid <= (r_state == c_ST_RUN) && w_can_issue;
                    end
                end

                default: begin
                    r_state <= c_ST_IDLE;
                    r_busy  <= 1'b0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    // Data lines stay quiet whenever no word is offered.
    assign DpData    = r_valid ? w_lfsr_q : '0;
    assign DpValidIn = r_valid;
    assign Busy      = r_busy;
    assign Done      = r_done;
    assign Timeout   = r_timeout;
    assign ProtoErr  = r_protoerr;
    assign PassCount = r_pass;
    assign FailCount = r_fail;

endmodule
`default_nettype wire

// File: tb/tb_peecc_run_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_peecc_run_controller
// Description : Self-checking bench for peecc_run_controller. A loopback
//               datapath model returns results after a programmable latency;
//               a scoreboard holds the expected word stream and the expected
//               tallies of every run, and a monitor compares DUT outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_peecc_run_controller;

    localparam int c_DW   = 18;
    localparam int c_CW   = 16;
    localparam int c_MAXO = 11;
    localparam int c_TO   = 64;

    logic            clk;
    logic            rst;
    logic            start;
    logic [c_CW-1:0] num_words;
    logic [c_DW-1:0] seed;
    logic [c_DW-1:0] dp_data;
    logic            dp_valid_in;
    logic            dp_ready;
    logic            dp_valid_out;
    logic            dp_is_equal;
    logic            busy;
    logic            done;
    logic            timeout;
    logic            proto_err;
    logic [c_CW-1:0] pass_count;
    logic [c_CW-1:0] fail_count;

    peecc_run_controller #(
        .DATA_W      (c_DW),
        .CNT_W       (c_CW),
        .MAX_OUTST   (c_MAXO),
        .TIMEOUT_CYC (c_TO)
    ) dut (
        .CLK        (clk),
        .RST        (rst),
        .Start      (start),
        .NumWords   (num_words),
        .Seed       (seed),
        .DpData     (dp_data),
        .DpValidIn  (dp_valid_in),
        .DpReady    (dp_ready),
        .DpValidOut (dp_valid_out),
        .DpIsEqual  (dp_is_equal),
        .Busy       (busy),
        .Done       (done),
        .Timeout    (timeout),
        .ProtoErr   (proto_err),
        .PassCount  (pass_count),
        .FailCount  (fail_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Reference LFSR: Galois, x^18 + x^11 + 1, shifting towards bit 0.
    function automatic logic [17:0] model_next(input logic [17:0] s);
        logic [17:0] taps;
        taps = 18'h0;
        taps[17] = 1'b1;   // x^18 term
        taps[10] = 1'b1;   // x^11 term
        return (s >> 1) ^ (s[0] ? taps : 18'h0);
    endfunction

    // ---------------- loopback datapath model ----------------
    int  lat        = 3;
    int  ready_mode = 0;   // 0 always, 1 toggling, 2 random, 3 never
    bit  dp_enable  = 1'b1;
    bit  stray_req  = 1'b0;
    bit  stray_now  = 1'b0;
    int  due[$];
    bit  eq_bits[$];

    initial begin
        dp_ready     = 1'b0;
        dp_valid_out = 1'b0;
        dp_is_equal  = 1'b0;
        forever begin
            @(negedge clk);
            dp_valid_out = 1'b0;
            dp_is_equal  = 1'b0;
            stray_now    = 1'b0;
            if (stray_req) begin
                dp_valid_out = 1'b1;
                dp_is_equal  = 1'b1;
                stray_now    = 1'b1;
                stray_req    = 1'b0;
            end else if (dp_enable && due.size() > 0 && due[0] <= cyc) begin
                void'(due.pop_front());
                dp_valid_out = 1'b1;
                dp_is_equal  = (eq_bits.size() > 0) ? eq_bits.pop_front() : 1'b1;
            end
            case (ready_mode)
                0:       dp_ready = 1'b1;
                1:       dp_ready = cyc[0];
                2:       dp_ready = ($urandom_range(0, 3) != 0);
                default: dp_ready = 1'b0;
            endcase
            #1;
            if (dp_valid_in && dp_ready) due.push_back(cyc + lat);
        end
    end

    // ---------------- scoreboard and monitor ----------------
    logic [17:0] exp_words[$];
    int          exp_pass[$];
    int          exp_fail[$];
    int          xfers      = 0;
    int          results    = 0;
    int          first_xfer = -1;
    int          done_cnt   = 0;
    int          done_cyc   = 0;
    int          start_cyc  = 0;
    bit          mon_en     = 1'b0;
    bit          prev_stall = 1'b0;
    logic [17:0] prev_data  = '0;

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!mon_en) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("hold_valid", dp_valid_in, 1);
                    check("hold_data", dp_data, prev_data);
                end
                if (dp_valid_in && dp_ready) begin
                    if (first_xfer < 0) first_xfer = cyc + 1;
                    check("inflight_limit", (xfers - results) < c_MAXO, 1);
                    if (exp_words.size() == 0) fail_now("extra_word");
                    else check("word", dp_data, exp_words.pop_front());
                    xfers++;
                end
                if (dp_valid_out && !stray_now) results++;
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                    if (exp_pass.size() == 0) begin
                        fail_now("unexpected_done");
                    end else begin
                        check("pass_count", pass_count, exp_pass.pop_front());
                        check("fail_count", fail_count, exp_fail.pop_front());
                        check("words_left", exp_words.size(), 0);
                    end
                end
                prev_stall = dp_valid_in && !dp_ready;
                prev_data  = dp_data;
            end
        end
    end

    // eq_mode: 0 all equal, 1 pattern 1,0,1,1,0 repeating, 2 random
    task automatic start_run(input int n, input logic [17:0] sd, input int eq_mode,
                             input bit expect_done);
        logic [17:0] s;
        logic [4:0]  pat;
        bit          b;
        int          p;
        int          f;
        pat = 5'b01101;
        p   = 0;
        f   = 0;
        @(negedge clk);
        #3;
        due.delete();
        eq_bits.delete();
        exp_words.delete();
        xfers      = 0;
        results    = 0;
        first_xfer = -1;
        s = (sd == 18'h0) ? 18'h1 : sd;
        for (int i = 0; i < n; i++) begin
            exp_words.push_back(s);
            s = model_next(s);
            if (eq_mode == 0)      b = 1'b1;
            else if (eq_mode == 1) b = pat[i % 5];
            else                   b = $urandom_range(0, 1) != 0;
            eq_bits.push_back(b);
            if (b) p++;
            else   f++;
        end
        if (expect_done) begin
            exp_pass.push_back(p);
            exp_fail.push_back(f);
        end
        @(negedge clk);
        num_words = c_CW'(n);
        seed      = sd;
        start     = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < budget && done_cnt == d0; i++) begin
            @(negedge clk);
            #3;
        end
        if (done_cnt == d0) fail_now("done_wait_expired");
    endtask

    initial begin
        int d;
        rst       = 1'b1;
        start     = 1'b0;
        num_words = '0;
        seed      = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #3;
        check("rst_busy", busy, 0);
        check("rst_valid", dp_valid_in, 0);
        check("rst_data", dp_data, 0);
        check("rst_done", done, 0);
        check("rst_timeout", timeout, 0);
        check("rst_protoerr", proto_err, 0);
        check("rst_pass", pass_count, 0);
        check("rst_fail", fail_count, 0);
        mon_en = 1'b1;

        // Basic run from seed 1, all results equal, single Done pulse.
        lat = 3; ready_mode = 0;
        start_run(5, 18'h1, 0, 1);
        wait_done(300);
        d = done_cnt;
        repeat (5) @(negedge clk);
        #3;
        check("done_once", done_cnt, d);

        // Mixed result pattern.
        start_run(5, 18'($urandom), 1, 1);
        wait_done(300);

        // Backpressure with toggling ready.
        ready_mode = 1; lat = 5;
        start_run(20, 18'($urandom), 2, 1);
        wait_done(1000);

        // Long latency pushes the in-flight limit.
        ready_mode = 0; lat = 14;
        start_run(25, 18'($urandom), 2, 1);
        wait_done(1000);

        // Randomised runs.
        for (int k = 0; k < 6; k++) begin
            ready_mode = $urandom_range(0, 2);
            lat        = $urandom_range(1, 15);
            start_run($urandom_range(1, 40), 18'($urandom), 2, 1);
            wait_done(3000);
        end

        // NumWords = 0.
        ready_mode = 0; lat = 3;
        start_run(0, 18'h5, 0, 1);
        wait_done(20);
        check("zero_done_latency", done_cyc - (start_cyc + 1), 3);
        check("zero_no_xfer", xfers, 0);

        // Seed 0 issues 1 as the first word.
        start_run(3, 18'h0, 0, 1);
        wait_done(300);

        // Stray result while nothing is in flight.
        ready_mode = 3;
        start_run(3, 18'($urandom), 0, 1);
        repeat (4) @(negedge clk);
        #3;
        stray_req = 1'b1;
        repeat (2) @(negedge clk);
        #3;
        check("stray_protoerr", proto_err, 1);
        check("stray_pass", pass_count, 0);
        check("stray_fail", fail_count, 0);
        ready_mode = 0;
        wait_done(300);

        // Watchdog: two words issued, no results ever returned.
        dp_enable = 1'b0; lat = 3;
        start_run(2, 18'($urandom), 0, 0);
        check("protoerr_cleared", proto_err, 0);
        d = done_cnt;
        for (int i = 0; i < 300 && !timeout; i++) begin
            @(negedge clk);
            #3;
        end
        if (!timeout) begin
            fail_now("timeout_wait_expired");
        end else begin
            check("timeout_latency", cyc - first_xfer, c_TO);
            check("timeout_busy", busy, 0);
        end
        repeat (5) @(negedge clk);
        #3;
        check("timeout_sticky", timeout, 1);
        check("timeout_no_done", done_cnt, d);
        dp_enable = 1'b1;
        start_run(3, 18'($urandom), 0, 1);
        check("timeout_cleared", timeout, 0);
        wait_done(300);

        // Reset in the middle of a run.
        ready_mode = 0; lat = 4;
        start_run(30, 18'($urandom), 0, 0);
        repeat (10) @(negedge clk);
        mon_en = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #3;
        check("midrst_busy", busy, 0);
        check("midrst_valid", dp_valid_in, 0);
        check("midrst_pass", pass_count, 0);
        check("midrst_fail", fail_count, 0);
        check("midrst_timeout", timeout, 0);
        repeat (20) @(negedge clk);
        #3;
        check("idle_results_pass", pass_count, 0);
        check("idle_results_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        n_checks++;
        n_fail++;
        $display("FAIL global_time_limit reached at cycle %0d", cyc);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
